line_burst_adapter: RTL
=======================

// Module: line_burst_adapter
// PURPOSE
//  Memory-side responder for the cache's pmem line interface: accepts 256-bit line
//  read/write requests and moves each line as 4 x 64-bit beats on a burst memory bus.
//  Sits between icache/dcache (arbiter) and the burst DRAM model; one transaction at a time.
// PARAMETERS
//  LINE_WIDTH   256  cache line width in bits
//  BURST_WIDTH  64   beat width in bits; BEATS = LINE_WIDTH/BURST_WIDTH = 4
//  ADDR_WIDTH   32   byte address width
// PORTS
//  clk           in   1    clock, rising-edge
//  rst_n         in   1    asynchronous active-low reset
//  pmem_read     in   1    line read request from cache, held until pmem_resp
//  pmem_write    in   1    line write request from cache, held until pmem_resp
//  pmem_address  in   32   line byte address from cache
//  pmem_wdata    in   256  write line from cache
//  pmem_rdata    out  256  assembled read line; valid while pmem_resp=1
//  pmem_resp     out  1    one-cycle completion pulse to cache
//  burst_read    out  1    burst read request to memory
//  burst_write   out  1    burst write request to memory
//  burst_address out  32   line-aligned address to memory
//  burst_wdata   out  64   current write beat
//  burst_rdata   in   64   current read beat, valid when burst_resp=1
//  burst_resp    in   1    per-beat acknowledge from memory
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, beat count 0, all outputs 0 incl. pmem_rdata.
//    Reset mid-transaction aborts immediately; no pmem_resp is issued.
//  - FSM states: IDLE, RD_BURST, WR_BURST, DONE.
//  - IDLE: pmem_write=1 -> latch pmem_wdata and address, go WR_BURST. Otherwise,
//    pmem_read=1 -> latch address, go RD_BURST. Both high: write wins (illegal from cache).
//  - Latched address is line-aligned: burst_address = {pmem_address[31:5], 5'b0}.
//  - Requests are registered: burst_read/burst_write rise the cycle after acceptance.
//    They stay high with a constant burst_address until the beat-3 burst_resp.
//  - RD_BURST: each cycle with burst_resp=1, burst_rdata is stored in slot cnt, i.e.
//    bits [64*cnt +: 64]; beat 0 = bits [63:0]. cnt increments. cnt=3 with burst_resp
//    -> DONE, cnt wraps to 0, burst_read drops the next cycle.
//  - WR_BURST: burst_wdata = latched line slot cnt, combinational from cnt.
//    Advance on burst_resp exactly as for reads. cnt=3 with burst_resp -> DONE.
//  - burst_resp=0 cycles are stalls: cnt, slot data and outputs hold. Stalls are unbounded;
//    there is no timeout.
//  - DONE: pmem_resp=1 for exactly one cycle. pmem_rdata = assembled line (reads).
//    Next state IDLE. pmem_rdata holds its value until the next read completes.
//  - Minimum latency: acceptance t0, burst req t1, beats t1..t4 (no stalls),
//    pmem_resp t5.
//  - The cache drops its request in the cycle after pmem_resp. If a request is still high
//    in IDLE, it is treated as a new transaction.
//  - Changes to pmem_read/write/address/wdata after acceptance are ignored until IDLE.
//  - burst_resp while in IDLE or DONE is ignored.
// TESTING
//  1. Read, no stalls: addr 0x0000_1234, beats 64'hA..,B..,C..,D..
//     -> burst_address 0x0000_1220; pmem_rdata={D,C,B,A}; pmem_resp at t5, 1 cycle wide.
//  2. Write line 256'h{4:...,3:...,2:...,1:...} to 0x80
//     -> burst_wdata sequence slot0..slot3; burst_write high 4 cycles; one pmem_resp.
//  3. Read with burst_resp low 3 cycles before beat 2 -> burst_wdata/cnt held;
//     line correct; pmem_resp at t8.
//  4. pmem_read and pmem_write high together in IDLE -> write burst performed;
//     no burst_read assertion.
//  5. rst_n pulsed low after beat 1 of a read -> all outputs 0 asynchronously.
//     After release, a new read of 0x40 completes correctly with cnt starting at 0.
//  6. Back-to-back reads with request held one cycle past pmem_resp
//     -> second transaction starts from IDLE; first pmem_rdata held until second DONE.

Source files
------------

// File: rtl/line_burst_adapter.sv
// Purpose : adapts a 256-bit cache line request into a 4-beat x 64-bit burst on the memory bus.
// Latency : request accepted t0, burst request t1, beats t1..t4, pmem_resp t5 (no stalls).
// Backpr. : burst_resp=0 stalls the burst indefinitely; the cache holds its request until pmem_resp.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   pmem_read/write/address/wdata      line request from the cache side
//   pmem_rdata, pmem_resp              assembled read line and one-cycle completion pulse
//   burst_read/write/address/wdata     burst request and current write beat to memory
//   burst_rdata, burst_resp            current read beat and per-beat acknowledge from memory
module line_burst_adapter #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pmem_read,
    input  logic                   pmem_write,
    input  logic [ADDR_WIDTH-1:0]  pmem_address,
    input  logic [LINE_WIDTH-1:0]  pmem_wdata,
    output logic [LINE_WIDTH-1:0]  pmem_rdata,
    output logic                   pmem_resp,
    output logic                   burst_read,
    output logic                   burst_write,
    output logic [ADDR_WIDTH-1:0]  burst_address,
    output logic [BURST_WIDTH-1:0] burst_wdata,
    input  logic [BURST_WIDTH-1:0] burst_rdata,
    input  logic                   burst_resp
);

    localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF   = $clog2(LINE_WIDTH / 8);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t                               state_q, state_d;
    logic [CW-1:0]                        cnt_q;
    logic [ADDR_WIDTH-1:0]                addr_q;
    logic [BEATS-1:0][BURST_WIDTH-1:0]    wline_q;
    logic [BEATS-1:0][BURST_WIDTH-1:0]    rbuf_q;
    logic [BEATS-1:0][BURST_WIDTH-1:0]    rdata_q;
    logic                                 last_beat;
    logic [ADDR_WIDTH-1:0]                line_addr;

    // Byte offset within the line is dropped; memory always sees line-aligned addresses.
    logic unused_offset;
    assign unused_offset = ^pmem_address[OFF-1:0];
    assign line_addr     = {pmem_address[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};

    assign last_beat = burst_resp && (cnt_q == CW'(BEATS - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // Write takes priority if the cache ever raises both.
                if (pmem_write)     state_d = WR_BURST;
                else if (pmem_read) state_d = RD_BURST;
            end
            RD_BURST, WR_BURST: begin
                if (last_beat) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rbuf_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (pmem_write || pmem_read) addr_q <= line_addr;
                    if (pmem_write)              wline_q <= pmem_wdata;
                end
                RD_BURST: begin
                    if (burst_resp) begin
                        rbuf_q[cnt_q] <= burst_rdata;
                        cnt_q         <= cnt_q + CW'(1);
                        // Publish the full line together with its final beat so it is
                        // valid in the same cycle pmem_resp is high.
                        if (last_beat) rdata_q <= {burst_rdata, rbuf_q[BEATS-2:0]};
                    end
                end
                WR_BURST: begin
                    if (burst_resp) cnt_q <= cnt_q + CW'(1);
                end
                default: cnt_q <= '0;
            endcase
        end
    end

    assign burst_read    = (state_q == RD_BURST);
    assign burst_write   = (state_q == WR_BURST);
    assign burst_address = addr_q;
    assign burst_wdata   = burst_write ? wline_q[cnt_q] : '0;
    assign pmem_resp     = (state_q == DONE);
    assign pmem_rdata    = rdata_q;

endmodule
